muldiv_hilo_unit: RTL

MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_hilo_unit_if.sv | 25 ++
 rtl/muldiv_iter_core.sv | 54 +++++
 rtl/muldiv_hilo_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam int          ITER_COUNT  = 32;
    localparam int          CNT_W       = $clog2(ITER_COUNT);
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Request, direct-write and result signals of the HI/LO multiply/divide unit.
interface muldiv_hilo_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, wr_en, wr_sel, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_en, wr_sel, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes held in a 64-bit {upper, lower} accumulator.
module muldiv_iter_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc
);

    logic [63:0] acc_q;
    logic [63:0] acc_next;
    logic [31:0] opnd;
    logic        div_q;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [32:0] diff;

    // NOTE: every always_comb output gets a value on every path; a missed branch infers a latch.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd};
        rem_shift = acc_q[63:31];
        diff      = rem_shift - {1'b0, opnd};
        acc_next  = acc_q;
        if (div_q) begin
            // Borrow out of the 33-bit trial subtract means the divisor did not fit.
            if (!diff[32]) acc_next = {diff[31:0], acc_q[30:0], 1'b1};
            else           acc_next = {rem_shift[31:0], acc_q[30:0], 1'b0};
        end else begin
            acc_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc_q <= is_div ? {32'b0, a_mag} : {32'b0, b_mag};
            opnd  <= is_div ? b_mag : a_mag;
            div_q <= is_div;
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO multiply/divide unit: FSM, HI/LO registers, sign handling, mthi/mtlo port.
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise op[0] is ignored.
module muldiv_hilo_unit
    import muldiv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    muldiv_hilo_unit_if.slave   bus
);

    state_e             state;
    logic [CNT_W-1:0]   count;
    op_e                op_q;
    logic [31:0]        a_q;
    logic               b_zero;
    logic               busy_q, done_q, div_zero_q;
    logic [31:0]        hi_q, lo_q;

    logic [31:0]        a_mag, b_mag;
    logic [63:0]        acc;
    logic [63:0]        prod;
    logic [31:0]        quot, rem;
    logic [31:0]        res_hi, res_lo;
    logic               accept;

`ifdef MULDIV_SIGNED_EN
    logic neg_a_in, neg_b_in, neg_a, neg_b;

    assign neg_a_in = bus.op[0] & bus.a[31];
    assign neg_b_in = bus.op[0] & bus.b[31];
    assign a_mag    = neg_a_in ? -bus.a : bus.a;
    assign b_mag    = neg_b_in ? -bus.b : bus.b;
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
`endif

    assign accept = (state == S_IDLE) && bus.start;

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state == S_CALC),
        .is_div (bus.op[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    always_comb begin
        prod = acc;
        quot = acc[31:0];
        rem  = acc[63:32];
`ifdef MULDIV_SIGNED_EN
        // Quotient/product sign is the XOR of operand signs; remainder follows the dividend.
        if (neg_a ^ neg_b) begin
            prod = -acc;
            quot = -acc[31:0];
        end
        if (neg_a) rem = -acc[63:32];
`endif
        if (!op_is_div(op_q)) begin
            {res_hi, res_lo} = prod;
        end else if (b_zero) begin
            res_hi = a_q;
            res_lo = DIV_ZERO_LO;
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            op_q       <= OP_MULTU;
            a_q        <= '0;
            b_zero     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.wr_en) begin
                        if (bus.wr_sel) hi_q <= bus.wr_data;
                        else            lo_q <= bus.wr_data;
                    end
                    if (bus.start) begin
                        state  <= S_CALC;
                        count  <= CNT_W'(ITER_COUNT - 1);
                        op_q   <= op_e'(bus.op);
                        a_q    <= bus.a;
                        b_zero <= (bus.b == '0);
                        busy_q <= 1'b1;
`ifdef MULDIV_SIGNED_EN
                        neg_a  <= neg_a_in;
                        neg_b  <= neg_b_in;
`endif
                    end
                end
                S_CALC: begin
                    if (count == '0) state <= S_FIN;
                    else             count <= count - 1'b1;
                end
                S_FIN: begin
                    // Writes arriving here are dropped; the computed result owns HI/LO.
                    state      <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    div_zero_q <= op_is_div(op_q) & b_zero;
                    hi_q       <= res_hi;
                    lo_q       <= res_lo;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
